// File: rtl/quad_enc_gen.sv
// quad_enc_gen: turns single-cycle left/right step requests into A/B quadrature steps.
// Define QUAD_GEN_BOUNCE_EN to emit every edge as a new/old/new contact-bounce train.
module quad_enc_gen #(
   parameter int unsigned CLOCK_FREQ_MHZ = 100,
   parameter int unsigned EDGE_DELAY_US  = 100,
   parameter int unsigned PEND_W         = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic left_i,
   input  logic right_i,
   output logic a_o,
   output logic b_o,
   output logic busy_o,
   output logic step_done_o,
   output logic overflow_o
);
   localparam int unsigned TICK_W = 16;
   localparam int unsigned EXT_W  = PEND_W + 2;
   localparam int unsigned D      = CLOCK_FREQ_MHZ * EDGE_DELAY_US;
   localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(D - 1);
   localparam logic [TICK_W-1:0]       TICK_ONE  = TICK_W'(1);
   localparam logic signed [EXT_W-1:0] P_ONE     = EXT_W'(1);
   localparam logic signed [EXT_W-1:0] P_MAX     = EXT_W'((2 ** (PEND_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] P_MIN     = -P_MAX;

   typedef enum logic [2:0] {S_IDLE, S_E1, S_E2, S_E3, S_E4} state_t;

   state_t                    r_state;
   logic                      r_dir;
   logic [TICK_W-1:0]         r_tick;
   logic signed [PEND_W-1:0]  r_pend;
   logic [1:0]                r_ab;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_ovf;

   logic                      w_start;
   logic signed [EXT_W-1:0]   w_base;
   logic signed [EXT_W-1:0]   w_req;
   logic signed [EXT_W-1:0]   w_sum;
   logic                      w_drop;
   logic signed [PEND_W-1:0]  w_pend_nx;
   logic [TICK_W-1:0]         w_tick_inc;
   logic [1:0]                w_ab_hold;

   // {a,b} held during each state; dir=1 is a right step
   function automatic logic [1:0] levels(input state_t s, input logic dir);
      case (s)
         S_E1:    levels = dir ? 2'b01 : 2'b10;
         S_E2:    levels = 2'b00;
         S_E3:    levels = dir ? 2'b10 : 2'b01;
         default: levels = 2'b11;
      endcase
   endfunction

   function automatic state_t succ(input state_t s);
      case (s)
         S_E1:    succ = S_E2;
         S_E2:    succ = S_E3;
         S_E3:    succ = S_E4;
         default: succ = S_IDLE;
      endcase
   endfunction

   assign w_start    = (r_state == S_IDLE) && (r_pend != '0);
   assign w_tick_inc = r_tick + TICK_ONE;

   // Saturation is judged on the net result after the start adjustment
   always_comb begin
      w_base = EXT_W'(r_pend);
      if (w_start) begin
         w_base = r_pend[PEND_W-1] ? (w_base + P_ONE) : (w_base - P_ONE);
      end
      w_req = '0;
      if (right_i && !left_i) begin
         w_req = P_ONE;
      end else if (left_i && !right_i) begin
         w_req = -P_ONE;
      end
      w_sum     = w_base + w_req;
      w_drop    = (w_req != '0) && ((w_sum > P_MAX) || (w_sum < P_MIN));
      w_pend_nx = PEND_W'(w_drop ? w_base : w_sum);
   end

`ifdef QUAD_GEN_BOUNCE_EN
   localparam logic [TICK_W-1:0] BOUNCE_LO = TICK_W'(CLOCK_FREQ_MHZ);
   localparam logic [TICK_W-1:0] BOUNCE_HI = TICK_W'(2 * CLOCK_FREQ_MHZ);

   function automatic state_t pred(input state_t s);
      case (s)
         S_E2:    pred = S_E1;
         S_E3:    pred = S_E2;
         S_E4:    pred = S_E3;
         default: pred = S_IDLE;
      endcase
   endfunction

   // Second microsecond after an edge briefly reverts to the previous level
   assign w_ab_hold = ((w_tick_inc >= BOUNCE_LO) && (w_tick_inc < BOUNCE_HI)) ?
                      levels(pred(r_state), r_dir) : levels(r_state, r_dir);
`else
   assign w_ab_hold = levels(r_state, r_dir);
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_dir   <= 1'b0;
         r_tick  <= '0;
         r_pend  <= '0;
         r_ab    <= 2'b11;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_pend <= w_pend_nx;
         r_ovf  <= w_drop;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tick <= '0;
               if (w_start) begin
                  r_state <= S_E1;
                  r_dir   <= ~r_pend[PEND_W-1];
                  r_busy  <= 1'b1;
                  r_ab    <= levels(S_E1, ~r_pend[PEND_W-1]);
               end
            end
            default: begin
               if (r_tick == TICK_LAST) begin
                  r_tick <= '0;
                  if (r_state == S_E4) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_ab    <= 2'b11;
                  end else begin
                     r_state <= succ(r_state);
                     r_ab    <= levels(succ(r_state), r_dir);
                  end
               end else begin
                  r_tick <= w_tick_inc;
                  r_ab   <= w_ab_hold;
               end
            end
         endcase
      end
   end

   assign a_o         = r_ab[1];
   assign b_o         = r_ab[0];
   assign busy_o      = r_busy;
   assign step_done_o = r_done;
   assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_quad_enc_gen.sv
// tb_quad_enc_gen: random left/right requests checked against a step-schedule model via scoreboard queues.
module tb_quad_enc_gen;
   localparam int unsigned FREQ    = 2;
   localparam int unsigned EDGE_US = 5;
   localparam int unsigned PW      = 3;
   localparam int D    = FREQ * EDGE_US;
   localparam int PMAX = (1 << (PW - 1)) - 1;

   typedef struct {
      int         cyc;
      logic [1:0] ab;
   } ev_t;

   logic clk_i, rst_i, left_i, right_i;
   logic a_o, b_o, busy_o, step_done_o, overflow_o;

   int   cyc, n_chk, n_fail;
   int   m_pend, m_busy_end;
   ev_t  ab_q[$];
   int   done_q[$];
   int   ovf_q[$];
   logic [1:0] seq_r [4];
   logic [1:0] seq_l [4];

   quad_enc_gen #(
      .CLOCK_FREQ_MHZ(FREQ),
      .EDGE_DELAY_US (EDGE_US),
      .PEND_W        (PW)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .left_i     (left_i),
      .right_i    (right_i),
      .a_o        (a_o),
      .b_o        (b_o),
      .busy_o     (busy_o),
      .step_done_o(step_done_o),
      .overflow_o (overflow_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk_i);
         cyc++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: cycle %0d reached time limit", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected A/B transitions and completion for a step whose first edge lands at cycle s
   task automatic push_step(input int s, input bit dir);
      logic [1:0] prev, nv;
      ev_t e;
      prev = 2'b11;
      for (int k = 0; k < 4; k++) begin
         nv = dir ? seq_r[k] : seq_l[k];
         e.cyc = s + k * D;
         e.ab  = nv;
         ab_q.push_back(e);
`ifdef QUAD_GEN_BOUNCE_EN
         e.cyc = s + k * D + int'(FREQ);
         e.ab  = prev;
         ab_q.push_back(e);
         e.cyc = s + k * D + 2 * int'(FREQ);
         e.ab  = nv;
         ab_q.push_back(e);
`endif
         prev = nv;
      end
      done_q.push_back(s + 4 * D);
   endtask

   // Drive one cycle of requests and advance the model to the next clock edge
   task automatic drive(input bit l, input bit r);
      int  base, sum;
      bit  dir;
      left_i  = l;
      right_i = r;
      base    = m_pend;
      if (cyc >= m_busy_end && m_pend != 0) begin
         dir = (m_pend > 0);
         push_step(cyc + 1, dir);
         m_busy_end = cyc + 1 + 4 * D;
         base = dir ? m_pend - 1 : m_pend + 1;
      end
      sum = base + (r ? 1 : 0) - (l ? 1 : 0);
      if (sum > PMAX || sum < -PMAX) begin
         ovf_q.push_back(cyc + 1);
         m_pend = base;
      end else begin
         m_pend = sum;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i   = 1'b1;
      left_i  = 1'b0;
      right_i = 1'b0;
      ab_q.delete();
      done_q.delete();
      ovf_q.delete();
      m_pend     = 0;
      m_busy_end = 0;
      @(posedge clk_i);
      #1;
      check("rst_a", int'(a_o), 1);
      check("rst_b", int'(b_o), 1);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(step_done_o), 0);
      check("rst_ovf", int'(overflow_o), 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((cyc < m_busy_end || m_pend != 0) && guard < 3000) begin
         drive(1'b0, 1'b0);
         guard++;
      end
      check("drain_in_budget", int'(guard < 3000), 1);
      repeat (3) drive(1'b0, 1'b0);
   endtask

   // Monitor: pops expected events whenever the DUT shows an edge or pulse
   initial begin : monitor
      logic [1:0] prev_ab;
      ev_t e;
      int  x;
      prev_ab = 2'b11;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            prev_ab = {a_o, b_o};
         end else begin
            if ({a_o, b_o} != prev_ab) begin
               check("ab_edge_expected", int'(ab_q.size() > 0), 1);
               if (ab_q.size() > 0) begin
                  e = ab_q.pop_front();
                  check("ab_edge_cycle", cyc, e.cyc);
                  check("ab_edge_value", int'({a_o, b_o}), int'(e.ab));
                  check("busy_during_edge", int'(busy_o), 1);
               end
               prev_ab = {a_o, b_o};
            end
            if (ab_q.size() > 0 && ab_q[0].cyc < cyc) begin
               check("ab_edge_missed", cyc, ab_q[0].cyc);
               e = ab_q.pop_front();
            end
            if (step_done_o) begin
               check("done_expected", int'(done_q.size() > 0), 1);
               if (done_q.size() > 0) begin
                  x = done_q.pop_front();
                  check("done_cycle", cyc, x);
                  check("busy_at_done", int'(busy_o), 0);
                  check("ab_at_done", int'({a_o, b_o}), 3);
               end
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
               check("done_missed", cyc, done_q[0]);
               x = done_q.pop_front();
            end
            if (overflow_o) begin
               check("ovf_expected", int'(ovf_q.size() > 0), 1);
               if (ovf_q.size() > 0) begin
                  x = ovf_q.pop_front();
                  check("ovf_cycle", cyc, x);
               end
            end
            if (ovf_q.size() > 0 && ovf_q[0] < cyc) begin
               check("ovf_missed", cyc, ovf_q[0]);
               x = ovf_q.pop_front();
            end
         end
      end
   end

   initial begin : stimulus
      int x;
      n_chk   = 0;
      n_fail  = 0;
      seq_r   = '{2'b01, 2'b00, 2'b10, 2'b11};
      seq_l   = '{2'b10, 2'b00, 2'b01, 2'b11};
      rst_i   = 1'b1;
      left_i  = 1'b0;
      right_i = 1'b0;
      do_reset();
      repeat (4) drive(1'b0, 1'b0);

      // single right step
      drive(1'b0, 1'b1);
      drain();

      // simultaneous requests cancel
      drive(1'b1, 1'b1);
      repeat (3) begin
         drive(1'b0, 1'b0);
         check("busy_after_cancel", int'(busy_o), 0);
      end

      // three left steps back to back
      repeat (3) drive(1'b1, 1'b0);
      drain();

      // saturate the pending counter while busy
      repeat (8) drive(1'b0, 1'b1);
      drain();

      // random mix of requests
      for (int i = 0; i < 800; i++) begin
         x = int'($urandom_range(0, 11));
         case (x)
            0:       drive(1'b0, 1'b1);
            1:       drive(1'b1, 1'b0);
            2:       drive(1'b1, 1'b1);
            default: drive(1'b0, 1'b0);
         endcase
      end
      drain();

      // reset mid-step discards the step and any pending requests
      drive(1'b0, 1'b1);
      repeat (D + 3) drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      do_reset();
      repeat (4 * D + 5) drive(1'b0, 1'b0);
      check("busy_after_reset", int'(busy_o), 0);

      check("ab_queue_empty", ab_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);
      check("ovf_queue_empty", ovf_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/quad_enc_gen.md
# quad_enc_gen

Quadrature waveform generator: the transmit side of the rotary-encoder A/B interface. It converts single-cycle left/right step requests into debounce-safe A/B quadrature sequences on the encoder GPIO lines. It sits between control logic, or a test harness, and either the encoder pins or a loopback into the encoder decoder. Each request produces exactly one detent-to-detent cycle that the decoder reports as one step in the same direction.

## Interface
- CLOCK_FREQ_MHZ, 100, clock frequency in MHz; legal range 1..655.
- EDGE_DELAY_US, 100, hold time after each A/B edge. Must exceed the decoder debounce delay of 55 us.
- PEND_W, 4, width of the signed pending-step counter.
- Constraint: CLOCK_FREQ_MHZ*EDGE_DELAY_US ≤ 65535, so the tick counter is 16 bits.
- clk_i  in  1  system clock; every register updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- left_i  in  1  one-cycle request for one left step.
- right_i  in  1  one-cycle request for one right step.
- a_o  out  1  encoder A line.
- b_o  out  1  encoder B line.
- busy_o  out  1  high while a step sequence is in progress.
- step_done_o  out  1  one-cycle pulse when a step completes.
- overflow_o  out  1  one-cycle pulse when a request is dropped because the pending counter is saturated.

## Operation
- Rest (detent) state: a_o=1, b_o=1.
- Pending counter `pend` (signed, PEND_W bits):
  - right_i adds +1; left_i adds −1.
  - right_i and left_i in the same cycle cancel: no change, no overflow.
  - Saturation limits are ±(2^(PEND_W−1)−1). A request that would exceed a limit is dropped and overflow_o pulses on the next cycle.
  - Starting a step moves pend one unit toward 0. If a request arrives in the same cycle, both updates apply.
- FSM states: IDLE, E1, E2, E3, E4.
- IDLE → E1 when pend≠0. Direction = sign(pend), latched for the whole step. The first edge is applied on that transition.
- Ex → Ex+1 when the tick counter reaches D−1, where D = CLOCK_FREQ_MHZ*EDGE_DELAY_US. The next edge is applied on that transition.
- E4 → IDLE after D ticks. step_done_o pulses on that transition.
- Right sequence ({a,b}): 11 → 01 → 00 → 10 → 11. A rises while B=0.
- Left sequence ({a,b}): 11 → 10 → 00 → 01 → 11. A rises while B=1.
- A step in progress always completes. Opposite requests arriving mid-step only adjust pend.
- Only one output changes per edge, so the sequence is Gray-coded.

## Timing
- Reset values: a_o=1, b_o=1, busy_o=0, step_done_o=0, overflow_o=0, pend=0, state IDLE, tick counter 0.
- Assertion of rst_i mid-step forces the rest state on the next edge. Pending steps are discarded.
- Request accepted at cycle t with IDLE and pend=0:
  - pend≠0 at t+1.
  - First edge visible at t+2.
  - Edges follow at t+2+D, t+2+2D and t+2+3D.
  - IDLE, step_done_o pulse and a_o=b_o=1 hold at t+2+4D.
- busy_o is high from t+2 through t+1+4D.
- Back-to-back steps: the next first edge is at t+3+4D, one IDLE cycle between steps.
- Tick counter resets to 0 on every state transition.

## Configuration
- QUAD_GEN_BOUNCE_EN defined: every commanded edge is emitted as new, old, new levels on the changing line. Each level is held for CLOCK_FREQ_MHZ cycles (1 us), and the new level is then held for the remainder of D.
  - The edge start time is unchanged; total step duration is still 4D.
  - Requires D > 2*CLOCK_FREQ_MHZ.
- Not defined: clean single transitions.

## Test plan
- Reset: assert rst_i mid-step with CLOCK_FREQ_MHZ=100, EDGE_DELAY_US=100 → next cycle a_o=b_o=1, busy_o=0, pend=0.
- Single right_i pulse at cycle 10, D=10000 → {a,b} goes 01@12, 00@10012, 10@20012, 11@30012; step_done_o@40012.
- Three left_i pulses in consecutive cycles → three left sequences back to back; step_done_o three times, 40001 cycles apart; decoder loopback reports three left_o.
- PEND_W=3: eight right_i pulses while busy → pend saturates at +3; overflow_o pulses for each dropped request.
- right_i and left_i in the same cycle while IDLE with pend=0 → no step, busy_o stays 0, no overflow.
- With QUAD_GEN_BOUNCE_EN and a decoder loopback, one right_i → a_o/b_o show bounce pulses 100 cycles wide; decoder reports exactly one right_o.
